// File: rtl/calc_tx_pkg.sv
// Shared types and helpers for the calculator result transmitter.
package calc_tx_pkg;

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

  function automatic int beats(input int dataW, input int outSize);
    return dataW / outSize;
  endfunction

endpackage

// File: rtl/calc_tx_fifo.sv
// Count-based synchronous queue. A push into a full queue is still accepted
// when a pop happens in the same cycle.
module calc_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q, wrPtr_d, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rdPtr_q];
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    if (doPush && !doPop)      count_d = count_q + CNT_W'(1);
    else if (doPop && !doPush) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/calc_tx_serializer.sv
// Result transmitter: queues calculator results and serialises them MSB-first
// onto an OUTSIZE-lane bus, paced by a programmable divided clock ClkTx.
module calc_tx_serializer
  import calc_tx_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int OUTSIZE    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 32
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               SampleData,
  input  logic [DATA_W-1:0]  Result,
  input  logic               ConfigDiv,
  input  logic [DIV_W-1:0]   DivIn,
  output logic               StartTx,
  output logic               Busy,
  output logic               DOutValid,
  output logic [OUTSIZE-1:0] DataOut,
  output logic               ClkTx,
  output logic               Full,
  output logic               Overflow
);
  localparam int BEATS  = beats(DATA_W, OUTSIZE);
  localparam int BCNT_W = $clog2(BEATS) + 1;

  if ((DATA_W % OUTSIZE) != 0) begin : gBadLanes
    $error("calc_tx_serializer: DATA_W must be a multiple of OUTSIZE");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : gBadDepth
    $error("calc_tx_serializer: FIFO_DEPTH must be a power of two and at least 2");
  end

  tx_state_t         state_q;
  logic [DATA_W-1:0] shReg_q;
  logic [BCNT_W-1:0] beatCnt_q;
  logic [DIV_W-1:0]  divCnt_q, divReg_q;
  logic              clkTx_q, startTx_q, dOutValid_q, overflow_q;

  logic              fifoFull, fifoEmpty, pop;
  logic              divTick, fallTick, lastBeat;
  logic [DATA_W-1:0] fifoData;

  calc_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) uFifo (
    .clk     (clk),
    .reset   (Reset),
    .push_i  (SampleData),
    .pop_i   (pop),
    .wdata_i (Result),
    .rdata_o (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // A word is popped either from idle or on the last falling toggle of a frame,
  // which is what makes back-to-back frames gapless.
  assign divTick  = (state_q == TX_SHIFT) && (divCnt_q == divReg_q);
  assign fallTick = divTick && clkTx_q;
  assign lastBeat = fallTick && (beatCnt_q == BCNT_W'(BEATS - 1));
  assign pop      = !fifoEmpty && ((state_q == TX_IDLE) || lastBeat);

  assign Busy      = (state_q == TX_SHIFT) || !fifoEmpty;
  assign Full      = fifoFull;
  assign Overflow  = overflow_q;
  assign StartTx   = startTx_q;
  assign DOutValid = dOutValid_q;
  assign ClkTx     = clkTx_q;
  assign DataOut   = shReg_q[DATA_W-1 -: OUTSIZE];

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= TX_IDLE;
      shReg_q     <= '0;
      beatCnt_q   <= '0;
      divCnt_q    <= '0;
      divReg_q    <= '0;
      clkTx_q     <= 1'b0;
      startTx_q   <= 1'b0;
      dOutValid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      startTx_q <= 1'b0;
      if (SampleData && fifoFull && !pop) overflow_q <= 1'b1;
      if (ConfigDiv && !Busy) divReg_q <= DivIn;

      case (state_q)
        TX_IDLE: begin
          if (pop) begin
            state_q     <= TX_SHIFT;
            shReg_q     <= fifoData;
            beatCnt_q   <= '0;
            divCnt_q    <= '0;
            clkTx_q     <= 1'b0;
            startTx_q   <= 1'b1;
            dOutValid_q <= 1'b1;
          end
        end
        TX_SHIFT: begin
          if (divTick) begin
            divCnt_q <= '0;
            clkTx_q  <= ~clkTx_q;
          end else begin
            divCnt_q <= divCnt_q + DIV_W'(1);
          end
          // DataOut only moves on falling toggles, so it is stable around each rising one.
          if (lastBeat) begin
            beatCnt_q <= '0;
            if (pop) begin
              shReg_q   <= fifoData;
              startTx_q <= 1'b1;
            end else begin
              state_q     <= TX_IDLE;
              shReg_q     <= '0;
              dOutValid_q <= 1'b0;
            end
          end else if (fallTick) begin
            shReg_q   <= shReg_q << OUTSIZE;
            beatCnt_q <= beatCnt_q + BCNT_W'(1);
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

endmodule
